uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_rx.sv | 107 ++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states and baud divisor.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is forced to zero when empty so the output is defined out of reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing/overrun pulses and a byte FIFO.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);

  rx_state_t     r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_rxs, w_tick, w_push, w_frame_err;
  logic          w_empty, w_full;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_timer == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;
    // The bit timer only runs while a frame is being sampled.
    if (r_state == S_START || r_state == S_DATA || r_state == S_STOP)
      w_timer_nxt = w_tick ? T_FULL : r_timer - 1'b1;
    case (r_state)
      S_IDLE: if (!w_rxs) begin
        w_state_nxt  = S_START;
        w_bitcnt_nxt = '0;
        w_timer_nxt  = T_HALF;
      end
      S_START: if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
      S_DATA: if (w_tick) begin
        w_shift_nxt  = {w_rxs, r_shift[7:1]};
        w_bitcnt_nxt = r_bitcnt + 1'b1;
        if (r_bitcnt == 3'd7) w_state_nxt = S_STOP;
      end
      S_STOP: if (w_tick) begin
        if (w_rxs) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_frame_err = 1'b1;
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (w_rxs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_sync   <= {r_sync[0], i_rxd};
      r_timer  <= w_timer_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (i_ready),
    .o_data  (o_data),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_valid     = ~w_empty;
  assign o_frame_err = w_frame_err;
  // A same-cycle pop frees the slot, so that push is not an overrun.
  assign o_overrun   = w_push & w_full & ~(o_valid & i_ready);
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=10: frames, glitch, framing error, overrun, reset.
module tb_uart_rx;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rxd = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overrun, o_busy;

  int         n_vec = 0;
  int         n_err = 0;
  int         fe_cnt = 0, ov_cnt = 0, vld_cyc = 0;
  logic [7:0] rxq[$];
  logic       v97, v98;

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rxd       (i_rxd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  // Observe pulses and accepted bytes mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ov_cnt++;
      if (o_valid) vld_cyc++;
      if (o_valid && i_ready) rxq.push_back(o_data);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_mon();
    fe_cnt = 0; ov_cnt = 0; vld_cyc = 0;
    rxq.delete();
  endtask

  // Frame cycle n: push/tick cycles fall at n=97, so o_valid is first visible at n=98.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rdy_at);
    logic [9:0] fr;
    int n;
    fr = {stop_bit, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      i_rxd = fr[i];
      for (int j = 0; j < 10; j++) begin
        tick();
        n++;
        if (n == 97) v97 = o_valid;
        if (n == 98) v98 = o_valid;
        if (rdy_at != 0 && n == rdy_at) i_ready = 1'b1;
        if (rdy_at != 0 && n == rdy_at + 1) i_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_rxd = 1'b1; i_ready = 1'b0;
    tick(3);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", o_valid); end
    n_vec++; if (o_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h exp 00", o_data); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", o_busy); end
    n_vec++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b exp 0", o_frame_err); end
    n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b exp 0", o_overrun); end
    rst = 1'b0;
    tick(5);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b exp 0", o_busy); end
  endtask

  task automatic test_single();
    clr_mon();
    i_ready = 1'b1;
    send_byte(8'hA5, 1'b1, 0);
    tick(5);
    i_ready = 1'b0;
    n_vec++; if (v97 !== 1'b0) begin n_err++; $display("FAIL a5_valid_before_push: got %b exp 0", v97); end
    n_vec++; if (v98 !== 1'b1) begin n_err++; $display("FAIL a5_valid_after_push: got %b exp 1", v98); end
    n_vec++; if (rxq.size() !== 1) begin n_err++; $display("FAIL a5_count: got %0d exp 1", rxq.size()); end
    n_vec++; if ((rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'hA5) begin n_err++; $display("FAIL a5_data: got %h exp a5", (rxq.size() > 0 ? rxq[0] : 8'hxx)); end
    n_vec++; if (vld_cyc !== 1) begin n_err++; $display("FAIL a5_valid_cycles: got %0d exp 1", vld_cyc); end
    n_vec++; if (fe_cnt + ov_cnt !== 0) begin n_err++; $display("FAIL a5_flags: got %0d exp 0", fe_cnt + ov_cnt); end
  endtask

  task automatic test_glitch();
    clr_mon();
    i_rxd = 1'b0;
    tick(3);
    i_rxd = 1'b1;
    tick(2);
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL glitch_in_start: got %b exp 1", o_busy); end
    tick(3);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL glitch_back_idle: got %b exp 0", o_busy); end
    tick(20);
    n_vec++; if (vld_cyc !== 0) begin n_err++; $display("FAIL glitch_valid: got %0d exp 0", vld_cyc); end
    n_vec++; if (fe_cnt + ov_cnt !== 0) begin n_err++; $display("FAIL glitch_flags: got %0d exp 0", fe_cnt + ov_cnt); end
  endtask

  task automatic test_frame_err();
    clr_mon();
    i_ready = 1'b1;
    send_byte(8'h3C, 1'b0, 0);
    tick(50);
    n_vec++; if (fe_cnt !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d exp 1", fe_cnt); end
    n_vec++; if (vld_cyc !== 0) begin n_err++; $display("FAIL ferr_no_push: got %0d exp 0", vld_cyc); end
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL ferr_wait_high: got %b exp 1", o_busy); end
    i_rxd = 1'b1;
    tick(5);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL ferr_release: got %b exp 0", o_busy); end
    send_byte(8'h5A, 1'b1, 0);
    tick(5);
    i_ready = 1'b0;
    n_vec++; if ((rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'h5A) begin n_err++; $display("FAIL ferr_recover_data: got %h exp 5a", (rxq.size() > 0 ? rxq[0] : 8'hxx)); end
    n_vec++; if (rxq.size() !== 1 || fe_cnt !== 1) begin n_err++; $display("FAIL ferr_recover_count: got %0d/%0d exp 1/1", rxq.size(), fe_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] got;
    clr_mon();
    i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1, 0);
    tick(5);
    n_vec++; if (ov_cnt !== 1) begin n_err++; $display("FAIL ovr_pulses: got %0d exp 1", ov_cnt); end
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b exp 1", o_valid); end
    i_ready = 1'b1;
    tick(10);
    i_ready = 1'b0;
    n_vec++; if (rxq.size() !== 4) begin n_err++; $display("FAIL ovr_drain_count: got %0d exp 4", rxq.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < rxq.size()) ? rxq[k] : 8'hxx;
      n_vec++; if (got !== 8'(k + 1)) begin n_err++; $display("FAIL ovr_drain_%0d: got %h exp %h", k, got, 8'(k + 1)); end
    end
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ovr_empty: got %b exp 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    clr_mon();
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1, 0);
    send_byte(8'h05, 1'b1, 97);
    tick(2);
    n_vec++; if (ov_cnt !== 0) begin n_err++; $display("FAIL full_pp_overrun: got %0d exp 0", ov_cnt); end
    n_vec++; if ((rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'h01) begin n_err++; $display("FAIL full_pp_pop: got %h exp 01", (rxq.size() > 0 ? rxq[0] : 8'hxx)); end
    n_vec++; if (o_data !== 8'h02) begin n_err++; $display("FAIL full_pp_head: got %h exp 02", o_data); end
    i_ready = 1'b1;
    tick(10);
    i_ready = 1'b0;
    n_vec++; if (rxq.size() !== 5) begin n_err++; $display("FAIL full_pp_count: got %0d exp 5", rxq.size()); end
    for (int k = 1; k < 5; k++) begin
      got = (k < rxq.size()) ? rxq[k] : 8'hxx;
      n_vec++; if (got !== 8'(k + 1)) begin n_err++; $display("FAIL full_pp_drain_%0d: got %h exp %h", k, got, 8'(k + 1)); end
    end
  endtask

  task automatic test_mid_reset();
    clr_mon();
    i_ready = 1'b0;
    send_byte(8'h33, 1'b1, 0);
    tick(5);
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mrst_buffered: got %b exp 1", o_valid); end
    i_rxd = 1'b0; tick(10);
    i_rxd = 1'b1; tick(10);
    tick(5);
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL mrst_in_data: got %b exp 1", o_busy); end
    rst = 1'b1;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b exp 0", o_valid); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b exp 0", o_busy); end
    rst = 1'b0;
    tick(20);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL mrst_stays_idle: got %b exp 0", o_busy); end
    clr_mon();
    i_ready = 1'b1;
    send_byte(8'h12, 1'b1, 0);
    tick(5);
    i_ready = 1'b0;
    n_vec++; if (rxq.size() !== 1) begin n_err++; $display("FAIL mrst_rx_count: got %0d exp 1", rxq.size()); end
    n_vec++; if ((rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'h12) begin n_err++; $display("FAIL mrst_rx_data: got %h exp 12", (rxq.size() > 0 ? rxq[0] : 8'hxx)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
